// File: rtl/master_slave_jk_flip_flop.sv
`default_nettype none
// ============================================================================
//  Module   : master_slave_jk_flip_flop
//  Brief    : WIDTH independent master-slave JK bit-slices on a shared clock.
//             The master is transparent while clk is high. The slave takes
//             the master value on each falling edge. rst_n clears both
//             stages asynchronously.
//  Revision : 1.0 - initial release
// ============================================================================
module master_slave_jk_flip_flop #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clk,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] m_q,
  input  logic             rst_n
);

  // Slave stage state. It is the only storage in the design. While clk is
  // low, the master would only repeat what the slave captured at the last
  // falling edge, so the held master value can be taken directly from here.
  logic [WIDTH-1:0] r_q;

  // JK next-state value computed from the current slave state.
  logic [WIDTH-1:0] w_master_next;

  // JK decode, one independent slice per bit.
  always_comb begin
    w_master_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({j[i], k[i]})
        2'b00:   w_master_next[i] = r_q[i];   // hold
        2'b10:   w_master_next[i] = 1'b1;     // set
        2'b01:   w_master_next[i] = 1'b0;     // reset
        default: w_master_next[i] = ~r_q[i];  // toggle
      endcase
    end
  end

  // Master stage: cleared by reset, transparent while clk is high, and
  // holding while clk is low. During the low phase the held value is r_q,
  // because r_q captured exactly the master value at the falling edge. The
  // master stays 0 after a reset release in the low phase, because reset
  // also cleared r_q.
  always_comb begin
    m_q = '0;
    if (rst_n && clk) begin
      m_q = w_master_next;
    end else if (rst_n) begin
      m_q = r_q;
    end
  end

  // Slave stage: captures the master value on the falling edge of clk.
  // The JK function is evaluated from r_q as it was before the edge, so the
  // slave cannot race its own update. Toggle therefore happens exactly once
  // per period.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_master_next;
    end
  end

  // Output drive: q_n is the complement of q at all times.
  always_comb begin
    q   = r_q;
    q_n = ~r_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_master_slave_jk_flip_flop.sv
`default_nettype none
// ============================================================================
//  Module   : tb_master_slave_jk_flip_flop
//  Brief    : Directed self-checking bench for master_slave_jk_flip_flop
//             (WIDTH=1 and WIDTH=4 instances on a shared clock and reset).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_master_slave_jk_flip_flop;

  logic       clk;
  logic       rst_n;
  logic       j;
  logic       k;
  logic       q;
  logic       q_n;
  logic       m_q;
  logic [3:0] j4;
  logic [3:0] k4;
  logic [3:0] q4;
  logic [3:0] q_n4;
  logic [3:0] m_q4;

  int vectors;
  int miscompares;

  master_slave_jk_flip_flop #(.WIDTH(1)) dut1 (
    .j(j), .k(k), .clk(clk), .q(q), .q_n(q_n), .m_q(m_q), .rst_n(rst_n)
  );

  master_slave_jk_flip_flop #(.WIDTH(4)) dut4 (
    .j(j4), .k(k4), .clk(clk), .q(q4), .q_n(q_n4), .m_q(m_q4), .rst_n(rst_n)
  );

  // Compare one observed value against the expected value.
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check all three outputs of the 1-bit instance.
  task automatic chk1(input string tag, input logic eq, input logic em);
    chk({tag, ".q"},   {3'b000, q},   {3'b000, eq});
    chk({tag, ".q_n"}, {3'b000, q_n}, {3'b000, ~eq});
    chk({tag, ".m_q"}, {3'b000, m_q}, {3'b000, em});
  endtask

  // Raise clk, then sample 1ns after the edge.
  task automatic rise();
    #4 clk = 1'b1;
    #1;
  endtask

  // Lower clk, then sample 1ns after the edge.
  task automatic fall();
    #4 clk = 1'b0;
    #1;
  endtask

  logic [3:0] tog_exp;
  logic       prev_q;

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    j     = 1'b1;
    k     = 1'b1;
    j4    = 4'b1111;
    k4    = 4'b1111;
    #1;
    // Reset with the clock running and toggle requested.
    chk1("rst0", 1'b0, 1'b0);
    chk("rst0.q4",   q4,   4'b0000);
    chk("rst0.q_n4", q_n4, 4'b1111);
    chk("rst0.m_q4", m_q4, 4'b0000);
    rise();  chk1("rst_hi1", 1'b0, 1'b0);
    fall();  chk1("rst_lo1", 1'b0, 1'b0);
    rise();  chk1("rst_hi2", 1'b0, 1'b0);
    fall();  chk1("rst_lo2", 1'b0, 1'b0);
    j4 = 4'b0000;
    k4 = 4'b0000;

    // Release reset while clk is low: the master holds 0.
    #2 rst_n = 1'b1;
    #1 chk1("rel_lo", 1'b0, 1'b0);
    j = 1'b1; k = 1'b0;
    #1 chk1("set_lo_iso", 1'b0, 1'b0);

    // Set, then hold for two periods.
    rise();  chk1("set_hi", 1'b0, 1'b1);
    fall();  chk1("set_lo", 1'b1, 1'b1);
    j = 1'b0; k = 1'b0;
    rise();  chk1("hold1_hi", 1'b1, 1'b1);
    fall();  chk1("hold1_lo", 1'b1, 1'b1);
    rise();  chk1("hold2_hi", 1'b1, 1'b1);
    fall();  chk1("hold2_lo", 1'b1, 1'b1);

    // Reset through K, then hold.
    j = 1'b0; k = 1'b1;
    rise();  chk1("clr_hi", 1'b1, 1'b0);
    fall();  chk1("clr_lo", 1'b0, 1'b0);
    j = 1'b0; k = 1'b0;
    rise();  chk1("hold0_hi", 1'b0, 1'b0);
    fall();  chk1("hold0_lo", 1'b0, 1'b0);

    // Toggle for four periods from q=0: q goes 1,0,1,0 (bit i = period i).
    tog_exp = 4'b0101;
    j = 1'b1; k = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prev_q = ~tog_exp[i];
      rise();  chk1($sformatf("tog%0d_hi", i), prev_q, tog_exp[i]);
      fall();  chk1($sformatf("tog%0d_lo", i), tog_exp[i], tog_exp[i]);
    end

    // No ones-catching: a J pulse withdrawn before the falling edge.
    j = 1'b0; k = 1'b0;
    rise();  chk1("pulse_pre", 1'b0, 1'b0);
    #2 j = 1'b1;
    #1 chk1("pulse_on", 1'b0, 1'b1);
    j = 1'b0;
    #1 chk1("pulse_off", 1'b0, 1'b0);
    fall();  chk1("pulse_lo", 1'b0, 1'b0);

    // Master isolation while clk is low.
    j = 1'b1; k = 1'b0;
    #1 chk1("iso_j", 1'b0, 1'b0);
    j = 1'b0; k = 1'b1;
    #1 chk1("iso_k", 1'b0, 1'b0);
    j = 1'b1; k = 1'b1;
    #1 chk1("iso_jk", 1'b0, 1'b0);

    // Reset mid-period during a pending toggle from q=1.
    j = 1'b1; k = 1'b0;
    rise();
    fall();  chk1("pre_rst", 1'b1, 1'b1);
    j = 1'b1; k = 1'b1;
    rise();  chk1("pre_rst_hi", 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk1("rst_async", 1'b0, 1'b0);
    fall();  chk1("rst_no_upd", 1'b0, 1'b0);
    rise();  chk1("rst_hi_ign", 1'b0, 1'b0);
    // Release while clk is high: the master is transparent at once.
    #1 rst_n = 1'b1;
    #1 chk1("rel_hi", 1'b0, 1'b1);
    fall();  chk1("rel_hi_lo", 1'b1, 1'b1);

    // WIDTH=4: load 0011, then j=1010 k=0110 gives 1001.
    j = 1'b0; k = 1'b0;
    j4 = 4'b0011; k4 = 4'b1100;
    rise();
    fall();  chk("w4_load.q", q4, 4'b0011);
    j4 = 4'b1010; k4 = 4'b0110;
    rise();
    chk("w4_hi.m_q", m_q4, 4'b1001);
    chk("w4_hi.q",   q4,   4'b0011);
    fall();
    chk("w4_lo.q",   q4,   4'b1001);
    chk("w4_lo.q_n", q_n4, 4'b0110);
    chk1("w4_lo.one", 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/master_slave_jk_flip_flop.md
MASTER_SLAVE_JK_FLIP_FLOP -- requirements
Module: master_slave_jk_flip_flop

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 1, number of independent JK bit-slices sharing clk and rst_n.
REQ-002 Port clk SHALL be: clk  input  1  single clock; master stage transparent while high, slave updates on falling edge.
REQ-003 Port rst_n SHALL be: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port j SHALL be: j  input  WIDTH  per-bit J (set) control.
REQ-005 Port k SHALL be: k  input  WIDTH  per-bit K (reset) control.
REQ-006 Port q SHALL be: q  output  WIDTH  slave stage state, the flip-flop output.
REQ-007 Port q_n SHALL be: q_n  output  WIDTH  bitwise complement of q at all times.
REQ-008 Port m_q SHALL be: m_q  output  WIDTH  master stage state, for observability.
REQ-009 Positional port order SHALL be j, k, clk, q, q_n, m_q, rst_n, so that a (j,k,clk,q) connection binds correctly.

Function
REQ-010 Each bit i SHALL be independent; no cross-bit interaction.
REQ-011 The master next value SHALL be computed from j[i], k[i] and the current slave q[i]:
- j=0, k=0: hold, m=q.
- j=1, k=0: set, m=1.
- j=0, k=1: reset, m=0.
- j=1, k=1: toggle, m=~q.
REQ-012 While clk=1 and rst_n=1, the master SHALL be transparent: m_q follows REQ-011 combinationally, and q SHALL NOT change.
REQ-013 While clk=0, the master SHALL hold its last value, and j/k changes SHALL have no effect on m_q or q.
REQ-014 On each falling clk edge with rst_n=1, q SHALL take the master value held at that edge. Latency is one falling edge. No change to q occurs on rising edges.
REQ-015 The block SHALL have no ones-catching. A j or k pulse during clk high that is withdrawn before the falling edge SHALL leave q unaffected.
REQ-016 In toggle mode (j=k=1), q SHALL invert exactly once per clock period, at the falling edge, and SHALL NOT oscillate during the high phase.
REQ-017 j/k changes coincident with the falling edge SHALL resolve so that the values before the edge are used.
REQ-018 All outputs SHALL be driven; q_n and m_q SHALL never be X or Z after reset.

Reset
REQ-019 rst_n=0 SHALL immediately, independent of clk, force m_q=0, q=0 and q_n=all-ones.
REQ-020 While rst_n=0, j, k and clk SHALL be ignored.
REQ-021 After rst_n rises:
- if clk=1, the master SHALL become transparent immediately.
- if clk=0, the master holds 0 until the next rising edge.
In both cases q SHALL first change at the next falling edge.
REQ-022 Reset asserted mid-period, including during a toggle, SHALL override any pending update. No update SHALL occur on a falling edge while rst_n=0.

Verification
REQ-023 Reset: rst_n=0 with clk running and j=k=1 -> q=0, q_n=1, m_q=0 throughout. Assert rst_n=0 while q=1 -> q=0 immediately, without waiting for a clock edge.
REQ-024 Set/hold: from q=0, j=1, k=0 through one clock period -> m_q=1 during clk high, q=1 after the falling edge. Then j=k=0 for two periods -> q stays 1.
REQ-025 Reset/hold: from q=1, j=0, k=1 for one period -> q=0 after the falling edge. Then j=k=0 -> q stays 0.
REQ-026 Toggle: from q=0, j=k=1 for four periods -> q sequence 1,0,1,0, one change per falling edge. No change on rising edges.
REQ-027 No ones-catching and master isolation:
- from q=0, pulse j=1 mid clk-high, then j=0 before the falling edge -> q stays 0.
- change j/k while clk=0 -> m_q and q unchanged.
REQ-028 WIDTH=4: j=4'b1010, k=4'b0110 from q=4'b0011 -> after one falling edge q=4'b1001, q_n=4'b0110.
